led_event_driver: RTL and testbench
===================================

// Module: led_event_driver
// PURPOSE
//  Output-side counterpart to the key debouncer: consumes clean one-cycle key-event
//  pulses and drives human-visible LED patterns. Per channel: toggle, stretch
//  (one-shot), blink-burst or free-running heartbeat. A shared millisecond
//  prescaler times everything. Sits between debounced key logic and board LED pins.
// PARAMETERS
//  N_CH      4        number of event/LED channels
//  TICK_DIV  50000    clk cycles per tick (1 ms at 50 MHz); must be >= 2
//  ON_MS     50       ticks LED is lit per stretch/blink/heartbeat phase; 1..1023
//  OFF_MS    50       ticks LED is dark between blinks in a burst; 1..1023
// PORTS
//  clk        in   1       system clock, 50 MHz
//  rst_n      in   1       asynchronous active-low reset
//  evt        in   N_CH    one-cycle event pulses, bit i = channel i, synchronous to clk
//  mode       in   2       00 toggle, 01 stretch, 10 blink burst, 11 heartbeat; all channels
//  blink_num  in   4       blinks per burst in mode 10; 0 = events ignored
//  led        out  N_CH    LED drive, 1 = lit, registered
//  busy       out  N_CH    1 while channel is in ON or OFF state (modes 01/10), registered
// BEHAVIOUR
//  Reset: led=0, busy=0, all states IDLE, prescaler=0, tick=0, heartbeat=0, mode_q=00.
//  Prescaler: counts 0..TICK_DIV-1, wraps; tick=1 for one clk when count==TICK_DIV-1.
//   Free-running, never reset by events, so phase lengths may be 1 clk to 1 tick short.
//  mode_q: registered copy of mode. When mode!=mode_q, every channel goes to IDLE,
//   led=0, busy=0, and the burst count clears on that edge; evt in that cycle is dropped.
//  Latency: evt at edge n -> led/busy updated at edge n+1.
//  Per-channel FSM: IDLE, ON, OFF. Fields: 10-bit ms counter, 4-bit burst count (rem).
//   Toggle (00): FSM stays IDLE; evt inverts led; busy=0.
//   Stretch (01): evt in IDLE -> ON, led=1, cnt=ON_MS. evt in ON reloads cnt=ON_MS.
//    On tick in ON: if cnt==1 -> IDLE, led=0; else cnt-1.
//   Blink (10): evt in IDLE with blink_num!=0 -> ON, led=1, cnt=ON_MS, rem=blink_num.
//    On tick in ON with cnt==1 -> OFF, led=0, cnt=OFF_MS.
//    On tick in OFF with cnt==1: if rem==1 -> IDLE; else rem-1, -> ON, led=1, cnt=ON_MS.
//    evt during ON/OFF is ignored (no retrigger, no queue).
//    blink_num is sampled only at burst start.
//   Heartbeat (11): evt ignored, busy=0. Shared heartbeat register has its own 10-bit
//    counter; it toggles every ON_MS ticks, and all led bits equal heartbeat.
//  Simultaneous: evt and tick in the same cycle -> evt action wins (load/reload).
//   A tick never decrements a freshly loaded counter.
//  busy = (state!=IDLE). Channels are independent except for the shared tick,
//   mode_q and heartbeat.
//  Reset mid-pattern: async; outputs reach reset values immediately, with no glitch
//   after release.
// STRUCTURE
//  Package led_evt_pkg: mode codes (MODE_TOGGLE/STRETCH/BLINK/HEART), state enum
//   (ST_IDLE/ST_ON/ST_OFF), CNT_W=10, REM_W=4.
//  Top: prescaler, mode_q/change detect, heartbeat, generate loop of N_CH instances.
//  Sub-module led_evt_chan: one FSM plus its counters. Inputs: clk, rst_n, evt, tick,
//   mode_q, mode_chg, blink_num. Outputs: led, busy.
// TESTING (TICK_DIV=4, ON_MS=3, OFF_MS=2, N_CH=4)
//  1 Toggle: mode=00, evt[0] pulse x3 -> led[0]=1,0,1, each one clk after the pulse;
//    busy=0; led[3:1]=0.
//  2 Stretch: mode=01, evt[1] once -> led[1]=1 for 9..12 clk, then 0. Retrigger at ~8 clk
//    -> lit 8 + 9..12 clk total.
//  3 Blink: mode=10, blink_num=3, evt[2] -> exactly 3 lit pulses separated by 2-tick gaps;
//    busy high throughout, low after the last OFF. Extra evt mid-burst -> still 3 pulses.
//    Repeat with blink_num=0 -> no activity.
//  4 Heartbeat: mode=11 -> all led toggle together every 12 clk; evt pulses no effect;
//    busy=0.
//  5 Mode change mid-burst: mode 10->01 during ON -> next edge led=0, busy=0; new evt
//    starts a stretch.
//  6 Reset: assert rst_n=0 mid-stretch and mid-burst -> led=0, busy=0 at once. After
//    release, evt+tick in the same clk -> full ON_MS loaded.

Source files
------------

// File: rtl/led_evt_pkg.sv
// Shared mode codes, channel state encoding and counter widths for the LED event driver.
package led_evt_pkg;

    localparam int CNT_W = 10;
    localparam int REM_W = 4;

    localparam logic [1:0] MODE_TOGGLE  = 2'b00;
    localparam logic [1:0] MODE_STRETCH = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_HEART   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_OFF  = 2'b10
    } chan_state_t;

endpackage

// File: rtl/led_event_driver_chan.sv
// One LED channel: toggle / stretch / blink-burst FSM with its ms and burst counters.
module led_evt_chan
    import led_evt_pkg::*;
#(
    parameter int ON_MS  = 50,
    parameter int OFF_MS = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             evt,
    input  logic             tick,
    input  logic [1:0]       mode_q,
    input  logic             mode_chg,
    input  logic [REM_W-1:0] blink_num,
    input  logic             heartbeat,
    output logic             led,
    output logic             busy
);

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_MS);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_MS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);

    chan_state_t      state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [REM_W-1:0] rem_r, rem_s;
    logic             led_r, led_s;
    logic             busy_r;

    // Next-state logic; evt is evaluated before tick so a load is never decremented in the same cycle.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        rem_s   = rem_r;
        led_s   = led_r;
        if (mode_chg) begin
            state_s = ST_IDLE;
            cnt_s   = {CNT_W{1'b0}};
            rem_s   = {REM_W{1'b0}};
            led_s   = 1'b0;
        end else begin
            case (mode_q)
                MODE_TOGGLE: begin
                    state_s = ST_IDLE;
                    if (evt) led_s = ~led_r;
                    else     led_s = led_r;
                end
                MODE_STRETCH: begin
                    case (state_r)
                        ST_IDLE: begin
                            if (evt) begin
                                state_s = ST_ON;
                                led_s   = 1'b1;
                                cnt_s   = ON_LOAD;
                            end else begin
                                led_s   = 1'b0;
                            end
                        end
                        ST_ON: begin
                            if (evt) begin
                                cnt_s = ON_LOAD;
                            end else if (tick) begin
                                if (cnt_r == CNT_ONE) begin
                                    state_s = ST_IDLE;
                                    led_s   = 1'b0;
                                end else begin
                                    cnt_s   = cnt_r - CNT_ONE;
                                end
                            end else begin
                                cnt_s = cnt_r;
                            end
                        end
                        default: begin
                            state_s = ST_IDLE;
                            led_s   = 1'b0;
                        end
                    endcase
                end
                MODE_BLINK: begin
                    case (state_r)
                        ST_IDLE: begin
                            if (evt && (blink_num != {REM_W{1'b0}})) begin
                                state_s = ST_ON;
                                led_s   = 1'b1;
                                cnt_s   = ON_LOAD;
                                rem_s   = blink_num;
                            end else begin
                                led_s   = 1'b0;
                            end
                        end
                        ST_ON: begin
                            if (tick && (cnt_r == CNT_ONE)) begin
                                state_s = ST_OFF;
                                led_s   = 1'b0;
                                cnt_s   = OFF_LOAD;
                            end else if (tick) begin
                                cnt_s   = cnt_r - CNT_ONE;
                            end else begin
                                cnt_s   = cnt_r;
                            end
                        end
                        ST_OFF: begin
                            if (tick && (cnt_r == CNT_ONE)) begin
                                if (rem_r == REM_ONE) begin
                                    state_s = ST_IDLE;
                                end else begin
                                    rem_s   = rem_r - REM_ONE;
                                    state_s = ST_ON;
                                    led_s   = 1'b1;
                                    cnt_s   = ON_LOAD;
                                end
                            end else if (tick) begin
                                cnt_s = cnt_r - CNT_ONE;
                            end else begin
                                cnt_s = cnt_r;
                            end
                        end
                        default: begin
                            state_s = ST_IDLE;
                            led_s   = 1'b0;
                        end
                    endcase
                end
                MODE_HEART: begin
                    state_s = ST_IDLE;
                    led_s   = heartbeat;
                end
                default: begin
                    state_s = ST_IDLE;
                    led_s   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; busy is derived from the next state so it moves with led.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            rem_r   <= {REM_W{1'b0}};
            led_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            rem_r   <= rem_s;
            led_r   <= led_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    assign led  = led_r;
    assign busy = busy_r;

endmodule

// File: rtl/led_event_driver.sv
// LED event driver top: shared ms prescaler, mode tracking, heartbeat and per-channel FSMs.
module led_event_driver
    import led_evt_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int TICK_DIV = 50000,
    parameter int ON_MS    = 50,
    parameter int OFF_MS   = 50
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] evt,
    input  logic [1:0]      mode,
    input  logic [3:0]      blink_num,
    output logic [N_CH-1:0] led,
    output logic [N_CH-1:0] busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] HB_LAST    = CNT_W'(ON_MS - 1);

    logic [PW-1:0]    presc_r;
    logic             tick_s;
    logic [1:0]       mode_q_r;
    logic             mode_chg_s;
    logic [CNT_W-1:0] hb_cnt_r;
    logic             hb_r;

    assign tick_s     = (presc_r == PRESC_LAST);
    assign mode_chg_s = (mode != mode_q_r);

    // Free-running prescaler; events never realign it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      presc_r <= {PW{1'b0}};
        else if (tick_s) presc_r <= {PW{1'b0}};
        else             presc_r <= presc_r + PW'(1);
    end

    // Registered mode copy used by every channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mode_q_r <= MODE_TOGGLE;
        else        mode_q_r <= mode;
    end

    // Shared heartbeat flips every ON_MS ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt_r <= {CNT_W{1'b0}};
            hb_r     <= 1'b0;
        end else if (tick_s) begin
            if (hb_cnt_r == HB_LAST) begin
                hb_cnt_r <= {CNT_W{1'b0}};
                hb_r     <= ~hb_r;
            end else begin
                hb_cnt_r <= hb_cnt_r + CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        led_evt_chan #(
            .ON_MS  (ON_MS),
            .OFF_MS (OFF_MS)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .evt       (evt[i]),
            .tick      (tick_s),
            .mode_q    (mode_q_r),
            .mode_chg  (mode_chg_s),
            .blink_num (blink_num),
            .heartbeat (hb_r),
            .led       (led[i]),
            .busy      (busy[i])
        );
    end

endmodule

// File: tb/tb_led_event_driver.sv
// Directed bench for led_event_driver with TICK_DIV=4, ON_MS=3, OFF_MS=2 (one tick = 4 clk).
module tb_led_event_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] evt;
    logic [1:0] mode;
    logic [3:0] blink_num;
    logic [3:0] led;
    logic [3:0] busy;

    int checks = 0;
    int errors = 0;

    led_event_driver #(
        .N_CH(4), .TICK_DIV(4), .ON_MS(3), .OFF_MS(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .evt       (evt),
        .mode      (mode),
        .blink_num (blink_num),
        .led       (led),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int ch);
        evt     = 4'b0000;
        evt[ch] = 1'b1;
        @(negedge clk);
        evt     = 4'b0000;
    endtask

    task automatic measure_high(input int ch, output int len);
        len = 0;
        while (led[ch] === 1'b1 && len < 100) begin
            len++;
            @(negedge clk);
        end
    endtask

    int len, pulses, lit, gap, n;
    logic prev;
    logic [3:0] prev_v;

    initial begin
        rst_n = 1'b0; evt = 4'b0000; mode = 2'b00; blink_num = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_led", 32'(led), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // toggle
        pulse(0); chk("tog1_led", 32'(led), 32'd1); chk("tog1_busy", 32'(busy), 32'd0);
        pulse(0); chk("tog2_led", 32'(led), 32'd0);
        pulse(0); chk("tog3_led", 32'(led), 32'd1);

        // stretch
        mode = 2'b01; @(negedge clk);
        chk("chg_clear_led", 32'(led), 32'd0);
        pulse(1);
        chk("str_led", 32'(led), 32'd2); chk("str_busy", 32'(busy), 32'd2);
        measure_high(1, len);
        chk("str_len_9_12", 32'(len >= 9 && len <= 12), 32'd1);
        chk("str_end_busy", 32'(busy), 32'd0);
        pulse(1);
        repeat (7) @(negedge clk);
        chk("str_hold_8", 32'(led[1]), 32'd1);
        pulse(1);
        measure_high(1, len);
        chk("str_retrig_len_9_12", 32'(len >= 9 && len <= 12), 32'd1);

        // blink burst with an extra event mid-burst
        mode = 2'b10; blink_num = 4'd3; @(negedge clk);
        pulse(2);
        pulses = 0; lit = 0; gap = 0; prev = 1'b0;
        for (int i = 0; i < 200 && busy[2] === 1'b1; i++) begin
            if (led[2] && !prev) pulses++;
            if (led[2]) lit++; else gap++;
            prev = led[2];
            evt = (i == 14) ? 4'b0100 : 4'b0000;
            @(negedge clk);
        end
        evt = 4'b0000;
        chk("blk_pulses", 32'(pulses), 32'd3);
        chk("blk_gap_clk", 32'(gap), 32'd24);
        chk("blk_lit_33_36", 32'(lit >= 33 && lit <= 36), 32'd1);
        chk("blk_end_busy", 32'(busy), 32'd0);
        chk("blk_end_led", 32'(led), 32'd0);
        blink_num = 4'd0;
        pulse(2);
        chk("blk0_led", 32'(led), 32'd0); chk("blk0_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        chk("blk0_led_late", 32'(led), 32'd0);

        // heartbeat
        mode = 2'b11; @(negedge clk);
        evt = 4'b1111; @(negedge clk); evt = 4'b0000;
        repeat (2) @(negedge clk);
        prev_v = led; n = 0;
        while (led === prev_v && n < 30) begin n++; @(negedge clk); end
        for (int k = 0; k < 2; k++) begin
            prev_v = led; n = 0;
            if (k == 0) evt = 4'b0101;
            do begin
                @(negedge clk); evt = 4'b0000; n++;
                chk("hb_all_equal", 32'(led == 4'hF || led == 4'h0), 32'd1);
            end while (led === prev_v && n < 30);
            chk("hb_period", 32'(n), 32'd12);
            chk("hb_busy", 32'(busy), 32'd0);
        end

        // mode change mid-burst
        mode = 2'b10; blink_num = 4'd3; @(negedge clk);
        pulse(3);
        chk("mc_burst_led", 32'(led), 32'd8); chk("mc_burst_busy", 32'(busy), 32'd8);
        repeat (2) @(negedge clk);
        mode = 2'b01; @(negedge clk);
        chk("mc_led", 32'(led), 32'd0); chk("mc_busy", 32'(busy), 32'd0);
        pulse(0);
        chk("mc_str_led", 32'(led), 32'd1); chk("mc_str_busy", 32'(busy), 32'd1);

        // async reset mid-stretch, then mid-burst
        @(negedge clk); #2 rst_n = 1'b0; #1;
        chk("rst_str_led", 32'(led), 32'd0); chk("rst_str_busy", 32'(busy), 32'd0);
        mode = 2'b10; blink_num = 4'd3;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        pulse(2);
        chk("rst_blk_start", 32'(busy), 32'd4);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0; #1;
        chk("rst_blk_led", 32'(led), 32'd0); chk("rst_blk_busy", 32'(busy), 32'd0);

        // evt lands on the first tick after release: full ON_MS must be loaded
        mode = 2'b01;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        evt = 4'b0010; @(negedge clk); evt = 4'b0000;
        chk("evt_tick_led", 32'(led), 32'd2);
        measure_high(1, len);
        chk("evt_tick_len", 32'(len), 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
